rr_sel_arbiter4: RTL and testbench
==================================

# rr_sel_arbiter4

- Round-robin 4-channel arbiter that generates the 2-bit `sel` for the 4:1 data mux directly downstream, plus a one-hot grant back to the requesters.
- Each grant is held until the consumer signals `done`, the requester drops its request, or a hold limit expires.
- A one-cycle gap with no grant separates consecutive grants, so the mux select never changes while a grant is live.

## Interface
- `HOLD_MAX`, default 8: maximum consecutive cycles a channel holds the grant. Legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in 4: per-channel request, level-sensitive. Bit i is channel i.
- `done` in 1: consumer pulse; the current transfer is complete.
- `sel` out 2: registered mux select, index of the granted or parked channel.
- `gnt` out 4: registered one-hot grant. All zero when idle.
- `busy` out 1: registered; 1 while in GRANT.

## Operation
- Internal state:
  - FSM with two states, IDLE and GRANT.
  - 2-bit round-robin pointer `ptr`.
  - 8-bit hold counter `cnt`.
- Reset (async assert, any time): `sel`=2'b00, `gnt`=4'b0000, `busy`=0, `ptr`=0, `cnt`=0, state IDLE.
- IDLE, `req`==0: stay in IDLE, outputs unchanged (see Configuration for `sel`).
- IDLE, `req`!=0:
  - Search `req` starting at index `ptr`, upward, mod 4; the first set bit wins (channel k).
  - At the edge: `sel`=k, `gnt`=1<<k, `busy`=1, `cnt`=0, go to GRANT.
- GRANT, release condition is any of:
  - `done`==1
  - `req[sel]`==0
  - `cnt`==HOLD_MAX-1
- GRANT, on release at the edge: `gnt`=0, `busy`=0, `ptr`=(sel+1) mod 4 (2-bit wrap, 3→0), go to IDLE.
- GRANT, no release: `cnt`=cnt+1, grant unchanged.
- Multiple release conditions in the same cycle produce a single release, with identical behaviour.
- `req` changes on other channels during GRANT have no effect until the next IDLE search.
- A channel that still requests after release is re-granted only when the round-robin search reaches it again. With a single requester, that is the next IDLE search.
- `done` while in IDLE is ignored.
- If the current channel's `req` bit is already low on the first GRANT cycle, release occurs at that edge, giving a one-cycle grant.

## Timing
- Request to grant latency:
  - `req` sampled at edge N in IDLE → `gnt`/`sel`/`busy` valid after edge N.
  - A requester raising `req` in cycle N sees `gnt` in cycle N+1.
- Release latency: a condition present in cycle M (sampled at edge M+1) → `gnt`=0 from cycle M+1.
- Gap: exactly one IDLE cycle (`gnt`=0) between any two grants. A new grant can appear no earlier than two edges after release.
- Maximum grant length: `gnt` is high for at most HOLD_MAX consecutive cycles.
- Minimum grant length: 1 cycle.
- `sel` changes only at the edge that enters GRANT, or as described in Configuration. It never changes while `gnt`!=0.
- Reset mid-grant: outputs clear immediately and asynchronously. After deassertion, the first search starts at channel 0.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `RR_SEL_ARB_PARK_EN`.
- Defined: in IDLE, `sel` parks on the last granted channel and holds that value until the next grant.
- Undefined: `sel` returns to 2'b00 at the edge that enters IDLE.
- Reset value of `sel` is 2'b00 in both builds.
- Grant ordering and timing are identical in both builds.

## Test plan
- Reset: `rst_n`=0 with `req`=4'b1111 → `sel`=00, `gnt`=0000, `busy`=0, held throughout reset.
- Single requester: `req`=0001 set at cycle 0, `done` pulsed in cycle 3.
  - Required: `gnt`=0001 and `sel`=00 in cycles 1–3, `gnt`=0000 in cycle 4, `gnt`=0001 again in cycle 5.
- Rotation: `req`=1111 held, `done` pulsed in every cycle where `gnt`!=0.
  - Required `gnt` sequence: 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
  - Required `sel` in granted cycles: 00, 01, 10, 11, 00.
- Hold limit: HOLD_MAX=8, `req`=0011 held, `done`=0.
  - Required: `gnt`=0001 for exactly 8 cycles, 1 cycle of 0000, then `gnt`=0010 for 8 cycles.
- Request drop and simultaneous release: channel 2 granted, then `req[2]`→0 together with `done`=1 in the same cycle.
  - Required: a single release; `gnt`=0000 in the next cycle; `ptr` advances to 3.
  - Required: with `req`=0101 at that point, the next grant is 0001 (search 3→0).
- Async reset mid-grant, run in both macro builds:
  - Setup: channel 3 granted, `rst_n` pulsed low between edges.
  - Required: `gnt`=0000 immediately; after release with `req`=1010, the first grant is 0010.
  - Required, PARK build: `sel` stays 01 after that grant's release.
  - Required, non-PARK build: `sel` returns to 00 after that grant's release.

Source files
------------

// File: rtl/rr_sel_arbiter4.sv
// rtl/rr_sel_arbiter4.sv - round-robin 4-channel arbiter driving a 4:1 mux select (optional macro: RR_SEL_ARB_PARK_EN)
module rr_sel_arbiter4 #(
   parameter int unsigned HOLD_MAX = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic       done,
   output logic [1:0] sel,
   output logic [3:0] gnt,
   output logic       busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(HOLD_MAX - 1);

   state_t     state_q, state_d;
   logic [1:0] ptr_q, ptr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] sel_q, sel_d;
   logic [3:0] gnt_q, gnt_d;
   logic       busy_q, busy_d;

   logic       found;
   logic [1:0] win;
   logic       release_w;

   // Round-robin search: first requesting channel at or above ptr, wrapping mod 4.
   always_comb begin
      found = 1'b0;
      win   = ptr_q;
      for (int i = 0; i < 4; i++) begin
         logic [1:0] idx;
         idx = ptr_q + 2'(i);
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = idx;
         end
      end
   end

   // Any single release cause ends the grant; coincident causes collapse into one release.
   assign release_w = done | ~req[sel_q] | (cnt_q == CNT_LAST);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (found)     state_d = GRANT;
         GRANT:   if (release_w) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output and datapath next values; all outputs leave through registers.
   always_comb begin
      sel_d  = sel_q;
      gnt_d  = gnt_q;
      busy_d = busy_q;
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               sel_d  = win;
               gnt_d  = 4'b0001 << win;
               busy_d = 1'b1;
               cnt_d  = 8'd0;
            end
         end
         GRANT: begin
            if (release_w) begin
               gnt_d  = 4'b0000;
               busy_d = 1'b0;
               ptr_d  = sel_q + 2'd1;
`ifdef RR_SEL_ARB_PARK_EN
               sel_d  = sel_q;
`else
               sel_d  = 2'b00;
`endif
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            gnt_d  = 4'b0000;
            busy_d = 1'b0;
         end
      endcase
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sel_q  <= 2'b00;
         gnt_q  <= 4'b0000;
         busy_q <= 1'b0;
         ptr_q  <= 2'b00;
         cnt_q  <= 8'd0;
      end else begin
         sel_q  <= sel_d;
         gnt_q  <= gnt_d;
         busy_q <= busy_d;
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
      end
   end

   assign sel  = sel_q;
   assign gnt  = gnt_q;
   assign busy = busy_q;

endmodule

// File: tb/tb_rr_sel_arbiter4.sv
// tb/tb_rr_sel_arbiter4.sv - scoreboard bench for rr_sel_arbiter4 with directed vectors
module tb_rr_sel_arbiter4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req = 4'b1111;
   logic       done = 1'b0;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       busy;

   rr_sel_arbiter4 #(.HOLD_MAX(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (req),
      .done (done),
      .sel  (sel),
      .gnt  (gnt),
      .busy (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic       done;
      logic [3:0] gnt;
      logic [1:0] sel;
   } vec_t;

   typedef struct {
      int         idx;
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       busy;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   task automatic add(input logic r, input logic [3:0] rq, input logic d,
                      input logic [3:0] g, input logic [1:0] s);
      vec_t v;
      v.rst_n = r; v.req = rq; v.done = d; v.gnt = g; v.sel = s;
      vecs.push_back(v);
   endtask

   task automatic add_n(input int n, input logic r, input logic [3:0] rq, input logic d,
                        input logic [3:0] g, input logic [1:0] s);
      for (int i = 0; i < n; i++) add(r, rq, d, g, s);
   endtask

   // Monitor: compare the DUT outputs against the oldest expected entry every falling edge.
   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            if (gnt !== e.gnt) begin
               errors++;
               $display("FAIL gnt row=%0d actual=%b required=%b", e.idx, gnt, e.gnt);
            end
            checks++;
            if (sel !== e.sel) begin
               errors++;
               $display("FAIL sel row=%0d actual=%b required=%b", e.idx, sel, e.sel);
            end
            checks++;
            if (busy !== e.busy) begin
               errors++;
               $display("FAIL busy row=%0d actual=%b required=%b", e.idx, busy, e.busy);
            end
         end
      end
   end

   // Driver: apply one row per cycle just after the rising edge and queue the outputs expected in that cycle.
   initial begin
      logic [1:0] last_sel;
      int         wait_cnt;
      // reset held with all requests active
      add_n(3, 1'b0, 4'b1111, 1'b0, 4'b0000, 2'd0);
      // single requester, done in cycle 3, regrant after one gap
      add  (1'b1, 4'b0001, 1'b0, 4'b0000, 2'd0);
      add_n(2, 1'b1, 4'b0001, 1'b0, 4'b0001, 2'd0);
      add  (1'b1, 4'b0001, 1'b1, 4'b0001, 2'd0);
      add  (1'b1, 4'b0001, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b0000, 1'b0, 4'b0001, 2'd0);
      // reset, then rotation with done on every granted cycle
      add  (1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0);
      add  (1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b1111, 1'b1, 4'b0010, 2'd1);
      add  (1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b1111, 1'b1, 4'b0100, 2'd2);
      add  (1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b1111, 1'b1, 4'b1000, 2'd3);
      add  (1'b1, 4'b1111, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b1111, 1'b1, 4'b0001, 2'd0);
      // reset, then hold limit of 8 cycles per channel
      add  (1'b0, 4'b0000, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b0011, 1'b0, 4'b0000, 2'd0);
      add_n(8, 1'b1, 4'b0011, 1'b0, 4'b0001, 2'd0);
      add  (1'b1, 4'b0011, 1'b0, 4'b0000, 2'd0);
      add_n(8, 1'b1, 4'b0011, 1'b0, 4'b0010, 2'd1);
      add  (1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0);
      // channel 2 granted, req[2] drop with done together, then search from 3 finds 0
      add  (1'b1, 4'b0100, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b0001, 1'b1, 4'b0100, 2'd2);
      add  (1'b1, 4'b0101, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b0000, 1'b1, 4'b0001, 2'd0);
      // channel 3 granted, async reset between edges, then restart from channel 0
      add  (1'b1, 4'b1000, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b1000, 1'b0, 4'b1000, 2'd3);
      add  (1'b0, 4'b1000, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b1010, 1'b0, 4'b0000, 2'd0);
      add  (1'b1, 4'b1010, 1'b1, 4'b0010, 2'd1);
      add_n(2, 1'b1, 4'b0000, 1'b0, 4'b0000, 2'd0);

      last_sel = 2'd0;
      for (int k = 0; k < vecs.size(); k++) begin
         exp_t e;
         @(posedge clk);
         #1;
         rst_n = vecs[k].rst_n;
         req   = vecs[k].req;
         done  = vecs[k].done;
         e.idx  = k;
         e.gnt  = vecs[k].gnt;
         e.busy = (vecs[k].gnt != 4'b0000);
         if (!vecs[k].rst_n) begin
            last_sel = 2'd0;
            e.sel    = 2'd0;
         end else if (e.busy) begin
            last_sel = vecs[k].sel;
            e.sel    = vecs[k].sel;
         end else begin
`ifdef RR_SEL_ARB_PARK_EN
            e.sel = last_sel;
`else
            e.sel = 2'd0;
`endif
         end
         sb.push_back(e);
      end

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL drain actual=%0d pending required=0 pending", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
